soc_dma_copy: RTL and testbench

- Word-copy DMA engine acting as a second **initiator** on the SoC memory bus (addr/rw/stb/ack/din/dout), the same bus the CPU drives into the BRAM controller.
- Reads a block of 32-bit words from a source address and writes them to a destination address, one transaction at a time.
- Used for boot-time memory initialisation and for bench traffic against soc_bram_ctl without a CPU.

---
 rtl/soc_dma_copy.sv | 180 ++++++++++++++++++
 tb/tb_soc_dma_copy.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_dma_copy.sv
// soc_dma_copy: word-copy DMA initiator on the SoC memory bus.
// Copies i_len 32-bit words from i_src to i_dst, one read then one write per word,
// with at most one bus transaction outstanding.
//
// Optional watchdog: define SOC_DMA_TIMEOUT_EN to abort a wait state after TIMEOUT
// cycles without i_ack (sets sticky o_err, pulses o_done). Without the macro, wait
// states block until i_ack and o_err stays 0.
//
// Ports:
//   i_clk, i_reset_n          clock, async active-low reset
//   i_start, i_src, i_dst,    start pulse and transfer descriptor (sampled in IDLE)
//   i_len
//   o_busy, o_done, o_err     status: busy window, completion pulse, sticky abort flag
//   o_addr, o_rw, o_dwrite,   bus request (rw: 1 = write)
//   o_stb
//   i_dread, i_ack            bus response
module soc_dma_copy #(
  parameter int unsigned ADDR_STEP = 4,
  parameter int unsigned LEN_WIDTH = 16,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_start,
  input  logic [31:0]          i_src,
  input  logic [31:0]          i_dst,
  input  logic [LEN_WIDTH-1:0] i_len,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err,
  output logic [31:0]          o_addr,
  output logic                 o_rw,
  output logic [31:0]          o_dwrite,
  input  logic [31:0]          i_dread,
  output logic                 o_stb,
  input  logic                 i_ack
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_WR_WAIT, S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [31:0]          src_q, src_d, dst_q, dst_d, data_q, data_d;
  logic [LEN_WIDTH-1:0] rem_q, rem_d;
  logic                 busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic                 stb_q, stb_d, rw_q, rw_d;
  logic [31:0]          addr_q, addr_d, dwrite_q, dwrite_d;

`ifdef SOC_DMA_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`else
  // TIMEOUT only matters when the watchdog is built in.
  logic unused_tmo;
  assign unused_tmo = ^32'(TIMEOUT);
`endif

  // Next-state and registered-output decode.
  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    rem_d    = rem_q;
    data_d   = data_q;
    err_d    = err_q;
    addr_d   = addr_q;
    rw_d     = rw_q;
    dwrite_d = dwrite_q;
    stb_d    = 1'b0;
`ifdef SOC_DMA_TIMEOUT_EN
    tmo_d    = '0;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          src_d   = i_src;
          dst_d   = i_dst;
          rem_d   = i_len;
          err_d   = 1'b0;
          state_d = (i_len == '0) ? S_DONE : S_RD_REQ;
        end
      end
      S_RD_REQ: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        if (i_ack) begin
          data_d  = i_dread;
          state_d = S_WR_REQ;
        end
      end
      S_WR_REQ: state_d = S_WR_WAIT;
      S_WR_WAIT: begin
        if (i_ack) begin
          src_d   = src_q + 32'(ADDR_STEP);
          dst_d   = dst_q + 32'(ADDR_STEP);
          rem_d   = rem_q - LEN_WIDTH'(1);
          state_d = (rem_q == LEN_WIDTH'(1)) ? S_DONE : S_RD_REQ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

`ifdef SOC_DMA_TIMEOUT_EN
    // Watchdog: counter restarts from 0 on every entry to a wait state.
    if ((state_q == S_RD_WAIT || state_q == S_WR_WAIT) && !i_ack) begin
      if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
        err_d   = 1'b1;
        state_d = S_DONE;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end
`endif

    // Bus outputs track the state being entered so o_stb coincides with the REQ cycle.
    if (state_d == S_RD_REQ) begin
      stb_d  = 1'b1;
      rw_d   = 1'b0;
      addr_d = src_d;
    end
    if (state_d == S_WR_REQ) begin
      stb_d    = 1'b1;
      rw_d     = 1'b1;
      addr_d   = dst_d;
      dwrite_d = data_d;
    end

    // Busy covers every non-IDLE state; done follows one cycle after DONE as busy drops.
    busy_d = (state_d != S_IDLE);
    done_d = (state_q == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= S_IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      rem_q    <= '0;
      data_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      stb_q    <= 1'b0;
      rw_q     <= 1'b0;
      addr_q   <= '0;
      dwrite_q <= '0;
`ifdef SOC_DMA_TIMEOUT_EN
      tmo_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      rem_q    <= rem_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      stb_q    <= stb_d;
      rw_q     <= rw_d;
      addr_q   <= addr_d;
      dwrite_q <= dwrite_d;
`ifdef SOC_DMA_TIMEOUT_EN
      tmo_q    <= tmo_d;
`endif
    end
  end

  assign o_busy   = busy_q;
  assign o_done   = done_q;
  assign o_err    = err_q;
  assign o_stb    = stb_q;
  assign o_rw     = rw_q;
  assign o_addr   = addr_q;
  assign o_dwrite = dwrite_q;

endmodule

// File: tb/tb_soc_dma_copy.sv
// Directed bench for soc_dma_copy: a single initial block drives stimulus and acts as
// the bus responder (64-word memory, configurable ack delay). Expected writes are
// queued when a copy is started and popped as the DUT's writes are acknowledged.
module tb_soc_dma_copy;

  localparam int unsigned LW = 16;
`ifdef SOC_DMA_TIMEOUT_EN
  localparam int unsigned TMO = 8;
`else
  localparam int unsigned TMO = 255;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   src = '0, dst = '0, dread = '0;
  logic [LW-1:0] len = '0;
  logic          ack = 1'b0;
  logic          o_busy, o_done, o_err, o_rw, o_stb;
  logic [31:0]   o_addr, o_dwrite;

  always #5 clk = ~clk;

  soc_dma_copy #(.ADDR_STEP(4), .LEN_WIDTH(LW), .TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(start), .i_src(src), .i_dst(dst),
    .i_len(len), .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_addr(o_addr),
    .o_rw(o_rw), .o_dwrite(o_dwrite), .i_dread(dread), .o_stb(o_stb), .i_ack(ack)
  );

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [64];
  logic [31:0] exp_addr_q [$];
  logic [31:0] exp_data_q [$];

  // responder state
  bit          pend = 1'b0;
  bit          ack_en = 1'b1;
  int          ack_dly = 0;
  int          p_cnt = 0;
  logic [31:0] p_addr = '0, p_data = '0;
  logic        p_rw = 1'b0;

  // per-test statistics
  int   cyc = 0, stb_cnt, wr_cnt, done_cnt, busy_cnt, first_busy, last_wr_ack, done_cyc, proto_bad;
  logic err_at_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    stb_cnt = 0; wr_cnt = 0; done_cnt = 0; busy_cnt = 0; proto_bad = 0;
    first_busy = -1; last_wr_ack = -1; done_cyc = -1; err_at_done = 1'b0;
  endtask

  // One clock: sample outputs at the falling edge and play the bus responder.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (o_busy) begin
      busy_cnt++;
      if (first_busy < 0) first_busy = cyc;
    end
    if (o_done) begin
      done_cnt++;
      done_cyc = cyc;
      err_at_done = o_err;
    end
    ack = 1'b0;
    if (pend) begin
      if (o_stb || o_addr !== p_addr || o_rw !== p_rw || (p_rw && o_dwrite !== p_data))
        proto_bad++;
      if (ack_en) begin
        if (p_cnt == 0) begin
          ack  = 1'b1;
          pend = 1'b0;
          if (p_rw) begin
            mem[p_addr[7:2]] = p_data;
            wr_cnt++;
            last_wr_ack = cyc;
            check("sb_write_expected", 32'(exp_addr_q.size() != 0), 32'd1);
            if (exp_addr_q.size() != 0) begin
              check("sb_write_addr", p_addr, exp_addr_q.pop_front());
              check("sb_write_data", p_data, exp_data_q.pop_front());
            end
          end else begin
            dread = mem[p_addr[7:2]];
          end
        end else begin
          p_cnt--;
        end
      end
    end else if (o_stb) begin
      pend   = 1'b1;
      p_addr = o_addr;
      p_rw   = o_rw;
      p_data = o_dwrite;
      p_cnt  = ack_dly;
      stb_cnt++;
    end
  endtask

  task automatic push_copy(input logic [31:0] s, input logic [31:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      exp_addr_q.push_back(d + 32'(4 * i));
      exp_data_q.push_back(mem[6'((s >> 2) + 32'(i))]);
    end
  endtask

  task automatic pulse_start(input logic [31:0] s, input logic [31:0] d, input int n);
    step();
    start = 1'b1; src = s; dst = d; len = LW'(n);
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      step();
      n++;
    end
    check(tag, 32'(done_cnt), 32'd1);
    repeat (3) step();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[0] = 32'h1111_1111; mem[1] = 32'h2222_2222;
    mem[2] = 32'h3333_3333; mem[3] = 32'h4444_4444;
    clear_stats();

    // Reset values
    repeat (2) step();
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_err", 32'(o_err), 32'd0);
    check("rst_stb", 32'(o_stb), 32'd0);
    check("rst_rw", 32'(o_rw), 32'd0);
    check("rst_addr", o_addr, 32'd0);
    check("rst_dwrite", o_dwrite, 32'd0);
    rst_n = 1'b1;
    step();

    // Zero-wait copy of 4 words, 0x00 -> 0x40: 4 cycles per word
    ack_dly = 0; ack_en = 1'b1;
    clear_stats();
    push_copy(32'h00, 32'h40, 4);
    pulse_start(32'h00, 32'h40, 4);
    wait_done(200, "zw_done_count");
    check("zw_xfer_cycles", 32'(last_wr_ack - first_busy + 1), 32'd16);
    check("zw_busy_cycles", 32'(busy_cnt), 32'd17);
    check("zw_done_after_busy", 32'(done_cyc - first_busy), 32'd17);
    check("zw_strobes", 32'(stb_cnt), 32'd8);
    check("zw_dst0", mem[16], 32'h1111_1111);
    check("zw_dst3", mem[19], 32'h4444_4444);
    check("zw_src0", mem[0], 32'h1111_1111);
    check("zw_src3", mem[3], 32'h4444_4444);
    check("zw_err", 32'(err_at_done), 32'd0);
    check("zw_sb_empty", 32'(exp_addr_q.size()), 32'd0);
    check("zw_protocol", 32'(proto_bad), 32'd0);

    // Delayed responder, d = 2: 2 + 2*(d+1) = 8 cycles per word
    ack_dly = 2;
    clear_stats();
    push_copy(32'h00, 32'h80, 2);
    pulse_start(32'h00, 32'h80, 2);
    wait_done(200, "dly_done_count");
    check("dly_xfer_cycles", 32'(last_wr_ack - first_busy + 1), 32'd16);
    check("dly_strobes", 32'(stb_cnt), 32'd4);
    check("dly_dst0", mem[32], 32'h1111_1111);
    check("dly_dst1", mem[33], 32'h2222_2222);
    check("dly_protocol", 32'(proto_bad), 32'd0);

    // len = 0: single-cycle DONE, no bus traffic
    ack_dly = 0;
    clear_stats();
    pulse_start(32'h10, 32'h90, 0);
    wait_done(20, "len0_done_count");
    check("len0_strobes", 32'(stb_cnt), 32'd0);
    check("len0_busy_cycles", 32'(busy_cnt), 32'd1);
    check("len0_done_timing", 32'(done_cyc - first_busy), 32'd1);

    // Start while busy is ignored
    clear_stats();
    push_copy(32'h00, 32'hA0, 3);
    pulse_start(32'h00, 32'hA0, 3);
    repeat (3) step();
    pulse_start(32'h00, 32'hC0, 8);
    wait_done(200, "sb_done_count");
    check("sb_strobes", 32'(stb_cnt), 32'd6);
    check("sb_writes", 32'(wr_cnt), 32'd3);
    check("sb_dst2", mem[42], 32'h3333_3333);
    check("sb_second_untouched", mem[48], 32'h0000_0000);
    check("sb_queue_empty", 32'(exp_addr_q.size()), 32'd0);

    // Reset in WR_WAIT of the second word
    ack_dly = 3;
    clear_stats();
    push_copy(32'h00, 32'hE0, 4);
    pulse_start(32'h00, 32'hE0, 4);
    for (int n = 0; n < 100 && !(pend && p_rw && wr_cnt == 1); n++) step();
    check("rm_reached_wr_wait", 32'(pend && p_rw && wr_cnt == 1), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rm_busy", 32'(o_busy), 32'd0);
    check("rm_stb", 32'(o_stb), 32'd0);
    check("rm_rw", 32'(o_rw), 32'd0);
    check("rm_addr", o_addr, 32'd0);
    check("rm_dwrite", o_dwrite, 32'd0);
    pend = 1'b0; ack = 1'b0;
    exp_addr_q.delete(); exp_data_q.delete();
    repeat (3) step();
    rst_n = 1'b1;
    repeat (3) step();
    check("rm_no_done", 32'(done_cnt), 32'd0);
    check("rm_one_write", 32'(wr_cnt), 32'd1);
    ack_dly = 0;
    clear_stats();
    push_copy(32'h00, 32'hF0, 4);
    pulse_start(32'h00, 32'hF0, 4);
    wait_done(200, "rm_restart_done");
    check("rm_restart_writes", 32'(wr_cnt), 32'd4);
    check("rm_restart_dst3", mem[63], 32'h4444_4444);

`ifdef SOC_DMA_TIMEOUT_EN
    // Responder never acks: abort after TMO wait cycles
    ack_en = 1'b0;
    clear_stats();
    pulse_start(32'h00, 32'h40, 2);
    wait_done(100, "tmo_done_count");
    check("tmo_err", 32'(err_at_done), 32'd1);
    check("tmo_timing", 32'(done_cyc - first_busy), 32'(TMO + 2));
    check("tmo_strobes", 32'(stb_cnt), 32'd1);
    // Late ack after the abort must be ignored
    ack_en = 1'b1;
    repeat (4) step();
    check("tmo_late_ack_busy", 32'(o_busy), 32'd0);
    check("tmo_late_ack_done", 32'(done_cnt), 32'd1);
    check("tmo_err_sticky", 32'(o_err), 32'd1);
    clear_stats();
    push_copy(32'h00, 32'h30, 1);
    pulse_start(32'h00, 32'h30, 1);
    check("tmo_err_cleared", 32'(o_err), 32'd0);
    wait_done(100, "tmo_restart_done");
    check("tmo_restart_data", mem[12], 32'h1111_1111);
`else
    check("noto_err_idle", 32'(o_err), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

endmodule
